arm_fetch_unit: RTL

- Instruction fetch stage directly upstream of the ARM core; produces the instruction word and its PC that the core decodes.
- Issues word-aligned requests to instruction memory over a req/ack handshake and buffers returned words in a DEPTH-entry prefetch FIFO.
- Presents instructions to the core with valid/ready and flushes on branch redirect or PC write.

---
 rtl/arm_fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/arm_fetch_unit.sv
// rtl/arm_fetch_unit.sv - instruction fetch stage with req/ack memory port and prefetch FIFO
// One request in flight at a time; a redirect flushes the FIFO and any in-flight word is dropped.
module arm_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [1:0]    state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [31:0]   addr_q, addr_n;
  logic [AW:0]   count, count_next;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];

  logic [31:0] redir_pc;
  logic        enq, deq, launch_ok;
  logic        unused_bits;

  assign redir_pc    = {redirect_pc[31:2], 2'b00};
  assign unused_bits = &{1'b0, redirect_pc[1:0]};

  assign enq = (state == REQ) && imem_ack && !redirect_valid;
  assign deq = (count != '0) && inst_ready;

  always_comb begin
    count_next = count;
    if (redirect_valid)
      count_next = '0;
    else if (enq && !deq)
      count_next = count + CNT_ONE;
    else if (!enq && deq)
      count_next = count - CNT_ONE;
  end

  // A new request only ever reserves a slot that is already free after this edge.
  assign launch_ok = !halt && (count_next < CNT_FULL);

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = addr_q;
    case (state)
      IDLE: begin
        if (redirect_valid)
          fetch_pc_n = redir_pc;
        if (launch_ok) begin
          state_n = REQ;
          addr_n  = fetch_pc_n;
        end
      end
      REQ: begin
        if (imem_ack) begin
          fetch_pc_n = redirect_valid ? redir_pc : fetch_pc + 32'd4;
          if (launch_ok) begin
            state_n = REQ;
            addr_n  = fetch_pc_n;
          end else begin
            state_n = IDLE;
          end
        end else if (redirect_valid) begin
          fetch_pc_n = redir_pc;
          state_n    = DISCARD;
        end
      end
      DISCARD: begin
        if (redirect_valid)
          fetch_pc_n = redir_pc;
        if (imem_ack) begin
          if (launch_ok) begin
            state_n = REQ;
            addr_n  = fetch_pc_n;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      addr_q   <= addr_n;
      count    <= count_next;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PTR_ONE;
        if (deq) rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_inst[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end

  assign imem_req   = (state != IDLE);
  assign imem_addr  = addr_q;
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? mem_inst[rd_ptr] : 32'd0;
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr]   : 32'd0;

endmodule
